// File: rtl/dmem_responder.sv
// dmem_responder: memory-side end of the RV32I core's load/store interface.
//
// Takes one request at a time over a valid/ready handshake. After the
// request is accepted, the block waits WAIT_CYCLES cycles, then performs
// the access. A byte, half or word load is sign- or zero-extended. A store
// writes only the byte lanes it selects. The result comes back as a single
// one-cycle resp_valid pulse. Misaligned, out-of-range and illegal-funct3
// accesses raise resp_err; a store that faults writes nothing.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   req_valid     core presents a request
//   req_ready     high only in IDLE (and not while rst is asserted)
//   req_write     1 = store, 0 = load
//   req_funct3    RV32I funct3
//   req_addr      byte address
//   req_wdata     store data; lane 0 holds the byte/half to store
//   resp_valid    one-cycle response pulse
//   resp_rdata    extended load data; 0 for stores and faults
//   resp_err      access fault, qualified by resp_valid
module dmem_responder #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err
);

    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StWait   = 2'd1;
    localparam logic [1:0] StAccess = 2'd2;
    localparam logic [1:0] StResp   = 2'd3;

    // Final count value of the wait counter; unused when WAIT_CYCLES is 0.
    localparam logic [3:0] WaitLast = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;

    // Holding registers for the accepted request
    logic             wr_q;
    logic [2:0]       f3_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;

    logic [WIDTH-1:0] mem [DEPTH_WORDS];

    logic             accept;
    logic [IdxW-1:0]  idx;
    logic [1:0]       size;
    logic             misaligned, out_of_range, bad_funct3, fault;
    logic [WIDTH-1:0] word, shifted, load_data, store_lanes;
    logic [7:0]       sel_byte;
    logic [15:0]      sel_half;
    logic [3:0]       byte_en;

    assign req_ready  = (state_q == StIdle) && !rst;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_q == StResp);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Access decode, all from the holding registers
    assign idx  = addr_q[IdxW+1:2];
    assign size = f3_q[1:0];

    assign misaligned   = ((size == 2'b01) && addr_q[0]) ||
                          ((size == 2'b10) && (addr_q[1:0] != 2'b00));
    assign out_of_range = addr_q[WIDTH-1:2] >= (WIDTH-2)'(DEPTH_WORDS);
    // Legal loads: 000,001,010,100,101. Legal stores: 000,001,010.
    assign bad_funct3   = wr_q ? (f3_q > 3'b010)
                               : ((f3_q == 3'b011) || (f3_q[2:1] == 2'b11));
    assign fault        = misaligned || out_of_range || bad_funct3;

    assign word     = mem[idx];
    assign shifted  = word >> {addr_q[1:0], 3'b000};
    assign sel_byte = shifted[7:0];
    assign sel_half = addr_q[1] ? word[31:16] : word[15:0];

    always_comb begin
        load_data = '0;
        case (f3_q)
            3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
            3'b010:  load_data = word;
            3'b100:  load_data = {24'd0, sel_byte};
            3'b101:  load_data = {16'd0, sel_half};
            default: load_data = '0;
        endcase
    end

    // Replicate the store data across lanes so the byte enables pick the right one.
    always_comb begin
        store_lanes = req_wdata_dummy_free();
        byte_en     = 4'b0000;
        case (size)
            2'b00: begin
                store_lanes = {4{wdata_q[7:0]}};
                byte_en     = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                store_lanes = {2{wdata_q[15:0]}};
                byte_en     = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                store_lanes = wdata_q;
                byte_en     = 4'b1111;
            end
        endcase
    end

    function automatic logic [WIDTH-1:0] req_wdata_dummy_free();
        return '0;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (WAIT_CYCLES > 0) ? StWait : StAccess;
                    cnt_d   = 4'd0;
                end
            end
            StWait: begin
                if (cnt_q == WaitLast) begin
                    state_d = StAccess;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StAccess: begin
                rdata_d = (fault || wr_q) ? '0 : load_data;
                err_d   = fault;
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= req_write;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Storage is not reset; rst in ACCESS suppresses the commit.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == StAccess) && wr_q && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[idx][8*i +: 8] <= store_lanes[8*i +: 8];
                end
            end
        end
    end

endmodule
